// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the Mini-MIPS multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  // LSB position of field `port` inside a packed bus of `width`-bit fields.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: busy bit per register, outstanding-load count and
// per-read-port busy flags with same-cycle writeback bypass.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             mark_ok, clr_ok, inc, dec;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO));
  endfunction

  always_comb begin
    mark_ok = mark_en && !is_zero(mark_addr);
    clr_ok  = wb_en && !is_zero(wb_addr);
    busy_d  = busy_q;
    if (clr_ok)  busy_d[wb_addr]   = 1'b0;
    if (mark_ok) busy_d[mark_addr] = 1'b1;
    // Set beats clear on the same entry, so a clear there never decrements.
    inc   = mark_ok && !busy_q[mark_addr];
    dec   = clr_ok && busy_q[wb_addr] && !(mark_ok && (mark_addr == wb_addr));
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CNT_ONE;
    else if (dec && !inc && (cnt_q != '0))
      cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_busy
    logic [ADDR_W-1:0] ra;
    assign ra         = rd_addr[port_lsb(g, ADDR_W) +: ADDR_W];
    assign rd_busy[g] = busy_q[ra] && !(wb_en && (wb_addr == ra)) && !is_zero(ra);
  end

endmodule

// File: rtl/mips_regfile_mp.sv
// Mini-MIPS register file: two write ports (ALU, load writeback), NUM_RD
// bypassed read ports and a pending-load scoreboard for decode stalls.
module mips_regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wa_ok, wb_ok;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO));
  endfunction

  // Port A is applied last so it overwrites port B on an address collision.
  always_comb begin
    wa_ok = wa_en && !is_zero(wa_addr);
    wb_ok = wb_en && !is_zero(wb_addr);
    mem_d = mem_q;
    if (wb_ok) mem_d[wb_addr] = wb_data;
    if (wa_ok) mem_d[wa_addr] = wa_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[port_lsb(g, ADDR_W) +: ADDR_W];
    assign rd_data[port_lsb(g, DATA_W) +: DATA_W] =
        is_zero(ra)                   ? '0      :
        (wa_en && (wa_addr == ra))    ? wa_data :
        (wb_en && (wb_addr == ra))    ? wb_data :
                                        mem_q[ra];
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .mark_en  (mark_en),
    .mark_addr(mark_addr),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Scoreboard bench: two configurations (2 ports/zero reg, 4 ports/no zero reg)
// driven in lockstep and checked against an array-based reference model.
module tb_mips_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wa_en, wb_en, mark_en;
  logic [4:0]  wa_addr, wb_addr, mark_addr;
  logic [31:0] wa_data, wb_data;
  logic [9:0]  ra_a;
  logic [19:0] ra_b;
  logic [63:0] rd_a;
  logic [1:0]  busy_a;
  logic [5:0]  cnt_a;
  logic [127:0] rd_b;
  logic [3:0]  busy_b;
  logic [5:0]  cnt_b;

  always #5 clk = ~clk;

  mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .rd_addr(ra_a), .rd_data(rd_a), .rd_busy(busy_a),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mark_en(mark_en), .mark_addr(mark_addr), .busy_cnt(cnt_a));

  mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(ra_b), .rd_data(rd_b), .rd_busy(busy_b),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mark_en(mark_en), .mark_addr(mark_addr), .busy_cnt(cnt_b));

  typedef struct packed {
    logic [63:0]  da;
    logic [1:0]   ba;
    logic [5:0]   ca;
    logic [127:0] db;
    logic [3:0]   bb;
    logic [5:0]   cb;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mem [2][32];
  bit          m_busy[2][32];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model index 0 has a hardwired r0, model index 1 does not.
  function automatic logic [31:0] m_read(input int m, input logic [4:0] a);
    if (m == 0 && a == 5'd0) return 32'h0;
    if (wa_en && wa_addr == a) return wa_data;
    if (wb_en && wb_addr == a) return wb_data;
    return m_mem[m][a];
  endfunction

  function automatic logic m_rbusy(input int m, input logic [4:0] a);
    if (m == 0 && a == 5'd0) return 1'b0;
    return m_busy[m][a] && !(wb_en && wb_addr == a);
  endfunction

  function automatic logic [5:0] m_cnt(input int m);
    int c = 0;
    for (int k = 0; k < 32; k++) c += int'(m_busy[m][k]);
    return 6'(c);
  endfunction

  task automatic m_clear();
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 32; k++) begin
        m_mem[m][k]  = 32'h0;
        m_busy[m][k] = 1'b0;
      end
  endtask

  task automatic m_step();
    for (int m = 0; m < 2; m++) begin
      bit zr = (m == 0);
      if (wb_en && !(zr && wb_addr == 0) && !(wa_en && wa_addr == wb_addr))
        m_mem[m][wb_addr] = wb_data;
      if (wa_en && !(zr && wa_addr == 0)) m_mem[m][wa_addr] = wa_data;
      if (wb_en && !(zr && wb_addr == 0)) m_busy[m][wb_addr] = 1'b0;
      if (mark_en && !(zr && mark_addr == 0)) m_busy[m][mark_addr] = 1'b1;
    end
  endtask

  task automatic cycle(input logic r, input logic wea, input logic [4:0] aa, input logic [31:0] ad,
                       input logic web, input logic [4:0] ba, input logic [31:0] bd,
                       input logic mk, input logic [4:0] ma,
                       input logic [9:0] raa, input logic [19:0] rbb);
    exp_t e;
    @(negedge clk);
    rst = r; wa_en = wea; wa_addr = aa; wa_data = ad;
    wb_en = web; wb_addr = ba; wb_data = bd; mark_en = mk; mark_addr = ma;
    ra_a = raa; ra_b = rbb;
    if (r) m_clear();
    for (int i = 0; i < 2; i++) begin
      e.da[i*32 +: 32] = m_read(0, raa[i*5 +: 5]);
      e.ba[i]          = m_rbusy(0, raa[i*5 +: 5]);
    end
    for (int i = 0; i < 4; i++) begin
      e.db[i*32 +: 32] = m_read(1, rbb[i*5 +: 5]);
      e.bb[i]          = m_rbusy(1, rbb[i*5 +: 5]);
    end
    e.ca = m_cnt(0);
    e.cb = m_cnt(1);
    q.push_back(e);
    if (!r) m_step();
  endtask

  // Directed helper: both configurations read the same two registers.
  task automatic d(input logic r, input logic wea, input logic [4:0] aa, input logic [31:0] ad,
                   input logic web, input logic [4:0] ba, input logic [31:0] bd,
                   input logic mk, input logic [4:0] ma, input logic [4:0] r0, input logic [4:0] r1);
    cycle(r, wea, aa, ad, web, ba, bd, mk, ma, {r1, r0}, {r1, r0, r1, r0});
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_data_a",  128'(rd_a),   128'(e.da));
        chk("rd_busy_a",  128'(busy_a), 128'(e.ba));
        chk("busy_cnt_a", 128'(cnt_a),  128'(e.ca));
        chk("rd_data_b",  rd_b,         e.db);
        chk("rd_busy_b",  128'(busy_b), 128'(e.bb));
        chk("busy_cnt_b", 128'(cnt_b),  128'(e.cb));
      end
    end
  end

  initial begin : driver
    rst = 1'b1; wa_en = 0; wa_addr = 0; wa_data = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    mark_en = 0; mark_addr = 0; ra_a = 0; ra_b = 0;
    m_clear();
    d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    d(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 9);
    for (int k = 0; k < 16; k++)
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, {5'(2*k+1), 5'(2*k)},
            {5'(31-2*k), 5'(30-2*k), 5'(2*k+1), 5'(2*k)});
    d(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1);
    d(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    d(0, 1, 7, 32'h11, 0, 0, 0, 0, 0, 7, 7);
    d(0, 0, 0, 0, 1, 7, 32'h22, 0, 0, 7, 0);
    d(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 7);
    d(0, 1, 3, 32'hAAAA, 1, 3, 32'hBBBB, 0, 0, 3, 0);
    d(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    d(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    d(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    d(0, 0, 0, 0, 1, 9, 32'h55, 0, 0, 9, 0);
    d(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    d(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    d(0, 0, 0, 0, 1, 9, 32'h66, 1, 9, 9, 0);
    d(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    d(0, 1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 0, 9);
    d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    d(0, 0, 0, 0, 1, 9, 32'h77, 1, 10, 0, 9);
    d(0, 1, 13, 32'h1234, 0, 0, 0, 1, 11, 10, 13);
    d(0, 0, 0, 0, 0, 0, 0, 1, 11, 11, 10);
    d(0, 1, 14, 32'h5678, 0, 0, 0, 0, 0, 13, 14);
    d(1, 0, 0, 0, 0, 0, 0, 0, 0, 13, 10);
    d(0, 0, 0, 0, 0, 0, 0, 0, 0, 14, 11);
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
            1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
            1'($urandom_range(0, 1)), rnd_addr(),
            {rnd_addr(), rnd_addr()},
            {rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()});
    end
    d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    #3;
    chk("queue_drained", 128'(q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
